// File: rtl/rvx_bus_pkg.sv
// Shared definitions for RVX bus stress blocks: FSM encodings and LFSR constants.
package rvx_bus_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_DELAY     = 3'd1;
   localparam state_t ST_ISSUE     = 3'd2;
   localparam state_t ST_WAIT_RESP = 3'd3;
   localparam state_t ST_RESPOND   = 3'd4;

   localparam logic [15:0] LFSR_MASK         = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   // Right-shifting Galois step; taps are folded in when the bit shifted out is 1.
   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return (cur >> 1) ^ (cur[0] ? LFSR_MASK : 16'h0000);
   endfunction

endpackage

// File: rtl/rvx_lfsr16.sv
// 16-bit Galois LFSR that free-runs outside reset; a zero seed would lock up, so it becomes 1.
module rvx_lfsr16
   import rvx_bus_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] seed,
   output logic [15:0] value
);

   logic [15:0] seed_nz;

   assign seed_nz = (seed == 16'h0000) ? 16'h0001 : seed;

   always_ff @(posedge clock) begin
      if (reset) value <= seed_nz;
      else       value <= lfsr_next(value);
   end

endmodule

// File: rtl/rvx_bus_stall_injector.sv
// Bus pass-through that holds each request for a pseudo-random number of cycles before
// forwarding it, to stress manager stall handling.
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | no transaction; accepts a manager request
// DELAY     | counting injected wait cycles
// ISSUE     | s_rrequest/s_wrequest pulse is on the bus
// WAIT_RESP | waiting for the subordinate response of latched kind
// RESPOND   | m_rresponse/m_wresponse pulse is on the bus
module rvx_bus_stall_injector
   import rvx_bus_pkg::*;
#(
   parameter int          MAX_WAIT_CYCLES = 7,
   parameter logic [15:0] LFSR_SEED       = LFSR_DEFAULT_SEED
)
(
   input  logic        clock,
   input  logic        reset,
   input  logic        stall_enable,
   input  logic [31:0] m_address,
   input  logic [31:0] m_wdata,
   input  logic [3:0]  m_wstrobe,
   input  logic        m_rrequest,
   input  logic        m_wrequest,
   output logic [31:0] m_rdata,
   output logic        m_rresponse,
   output logic        m_wresponse,
   output logic [31:0] s_address,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrobe,
   output logic        s_rrequest,
   output logic        s_wrequest,
   input  logic [31:0] s_rdata,
   input  logic        s_rresponse,
   input  logic        s_wresponse,
   output logic        protocol_error,
   output logic [31:0] stall_cycles_count
);

   localparam int W = $clog2(MAX_WAIT_CYCLES + 1);

   state_t      state;
   logic [W-1:0] wait_cnt;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [3:0]  lat_wstrobe;
   logic        lat_write;

   logic [15:0]  lfsr_value;
   logic         lfsr_unused;
   logic [W-1:0] delay_d;
   logic         any_req;
   logic         early_resp;

   rvx_lfsr16 u_lfsr (
      .clock (clock),
      .reset (reset),
      .seed  (LFSR_SEED),
      .value (lfsr_value)
   );

   assign lfsr_unused = ^lfsr_value;
   assign delay_d     = stall_enable ? lfsr_value[W-1:0] : '0;
   assign any_req     = m_rrequest | m_wrequest;
   assign early_resp  = (s_rresponse | s_wresponse) &&
                        (state == ST_IDLE || state == ST_DELAY || state == ST_ISSUE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state              <= ST_IDLE;
         wait_cnt           <= '0;
         lat_addr           <= '0;
         lat_wdata          <= '0;
         lat_wstrobe        <= '0;
         lat_write          <= 1'b0;
         m_rdata            <= '0;
         m_rresponse        <= 1'b0;
         m_wresponse        <= 1'b0;
         s_address          <= '0;
         s_wdata            <= '0;
         s_wstrobe          <= '0;
         s_rrequest         <= 1'b0;
         s_wrequest         <= 1'b0;
         protocol_error     <= 1'b0;
         stall_cycles_count <= '0;
      end else begin
         s_rrequest  <= 1'b0;
         s_wrequest  <= 1'b0;
         m_rresponse <= 1'b0;
         m_wresponse <= 1'b0;

         if ((any_req && state != ST_IDLE) || early_resp) protocol_error <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  lat_addr    <= m_address;
                  lat_wdata   <= m_wdata;
                  lat_wstrobe <= m_wstrobe;
                  lat_write   <= m_wrequest;
                  wait_cnt    <= delay_d;
                  if (m_rrequest && m_wrequest) protocol_error <= 1'b1;
                  if (delay_d != '0) begin
                     state <= ST_DELAY;
                  end else begin
                     // Zero delay skips DELAY, so the bus is driven straight from the inputs.
                     state      <= ST_ISSUE;
                     s_address  <= m_address;
                     s_wdata    <= m_wdata;
                     s_wstrobe  <= m_wstrobe;
                     s_rrequest <= ~m_wrequest;
                     s_wrequest <= m_wrequest;
                  end
               end
            end
            ST_DELAY: begin
               wait_cnt <= wait_cnt - 1'b1;
               if (stall_cycles_count != 32'hFFFF_FFFF)
                  stall_cycles_count <= stall_cycles_count + 32'd1;
               if (wait_cnt == W'(1)) begin
                  state      <= ST_ISSUE;
                  s_address  <= lat_addr;
                  s_wdata    <= lat_wdata;
                  s_wstrobe  <= lat_wstrobe;
                  s_rrequest <= ~lat_write;
                  s_wrequest <= lat_write;
               end
            end
            ST_ISSUE: begin
               state <= ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
               if (lat_write) begin
                  if (s_rresponse) protocol_error <= 1'b1;
                  if (s_wresponse) begin
                     state       <= ST_RESPOND;
                     m_wresponse <= 1'b1;
                  end
               end else begin
                  if (s_wresponse) protocol_error <= 1'b1;
                  if (s_rresponse) begin
                     state       <= ST_RESPOND;
                     m_rdata     <= s_rdata;
                     m_rresponse <= 1'b1;
                  end
               end
            end
            ST_RESPOND: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rvx_bus_stall_injector.sv
// Bench for rvx_bus_stall_injector: one-cycle TCM model, reference LFSR and a response
// scoreboard keyed on request cycle plus predicted delay.
module tb_rvx_bus_stall_injector;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        stall_enable = 1'b0;
   logic [31:0] m_address = '0;
   logic [31:0] m_wdata = '0;
   logic [3:0]  m_wstrobe = '0;
   logic        m_rrequest = 1'b0;
   logic        m_wrequest = 1'b0;
   logic [31:0] m_rdata;
   logic        m_rresponse;
   logic        m_wresponse;
   logic [31:0] s_address;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrobe;
   logic        s_rrequest;
   logic        s_wrequest;
   logic [31:0] s_rdata = '0;
   logic        s_rresponse;
   logic        s_wresponse;
   logic        protocol_error;
   logic [31:0] stall_cycles_count;

   logic tcm_rresp = 1'b0;
   logic tcm_wresp = 1'b0;
   logic inj_wresp = 1'b0;

   assign s_rresponse = tcm_rresp;
   assign s_wresponse = tcm_wresp | inj_wresp;

   always #5 clock = ~clock;

   rvx_bus_stall_injector dut (
      .clock              (clock),
      .reset              (reset),
      .stall_enable       (stall_enable),
      .m_address          (m_address),
      .m_wdata            (m_wdata),
      .m_wstrobe          (m_wstrobe),
      .m_rrequest         (m_rrequest),
      .m_wrequest         (m_wrequest),
      .m_rdata            (m_rdata),
      .m_rresponse        (m_rresponse),
      .m_wresponse        (m_wresponse),
      .s_address          (s_address),
      .s_wdata            (s_wdata),
      .s_wstrobe          (s_wstrobe),
      .s_rrequest         (s_rrequest),
      .s_wrequest         (s_wrequest),
      .s_rdata            (s_rdata),
      .s_rresponse        (s_rresponse),
      .s_wresponse        (s_wresponse),
      .protocol_error     (protocol_error),
      .stall_cycles_count (stall_cycles_count)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   typedef struct {
      logic        write;
      logic [31:0] rdata;
      int          issue_cyc;
      int          resp_cyc;
   } sb_item_t;

   sb_item_t sb_q[$];

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic [15:0] ref_lfsr = 16'hACE1;
   always @(posedge clock) begin
      if (reset) ref_lfsr <= 16'hACE1;
      else       ref_lfsr <= (ref_lfsr >> 1) ^ (ref_lfsr[0] ? 16'hB400 : 16'h0000);
   end

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
      return r;
   endfunction

   logic [31:0] mem     [int unsigned];
   logic [31:0] exp_mem [int unsigned];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [31:0] a);
      return exp_mem.exists(a) ? exp_mem[a] : 32'h0;
   endfunction

   // One-cycle tightly coupled memory.
   always @(posedge clock) begin
      tcm_rresp <= 1'b0;
      tcm_wresp <= 1'b0;
      if (!reset) begin
         if (s_rrequest) begin
            tcm_rresp <= 1'b1;
            s_rdata   <= mem_rd(s_address);
         end
         if (s_wrequest) begin
            mem[s_address] = merge(mem_rd(s_address), s_wdata, s_wstrobe);
            tcm_wresp <= 1'b1;
         end
      end
   end

   int last_issue_cyc = -1;
   int n_sreq = 0;
   int n_mresp = 0;

   always @(negedge clock) begin
      sb_item_t it;
      if (s_rrequest | s_wrequest) begin
         last_issue_cyc = cyc;
         n_sreq++;
      end
      if (m_rresponse | m_wresponse) begin
         n_mresp++;
         if (sb_q.size() == 0) begin
            chk("unexpected_resp", 32'(1), 32'(0));
         end else begin
            it = sb_q.pop_front();
            chk("resp_kind", 32'(m_wresponse), 32'(it.write));
            chk("resp_cycle", cyc, it.resp_cyc);
            chk("issue_cycle", last_issue_cyc, it.issue_cyc);
            if (!it.write) chk("rdata", m_rdata, it.rdata);
         end
      end
   end

   int exp_stall = 0;

   // Called just after a negedge; drives the request for one cycle.
   task automatic issue(input logic write, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic stall);
      int d;
      sb_item_t it;
      stall_enable = stall;
      d = stall ? int'(ref_lfsr[2:0]) : 0;
      m_address  = addr;
      m_wdata    = data;
      m_wstrobe  = strb;
      m_wrequest = write;
      m_rrequest = !write;
      it.write     = write;
      it.rdata     = write ? 32'h0 : exp_rd(addr);
      it.issue_cyc = cyc + 1 + d;
      it.resp_cyc  = cyc + 3 + d;
      sb_q.push_back(it);
      exp_stall += d;
      if (write) exp_mem[addr] = merge(exp_rd(addr), data, strb);
      @(negedge clock);
      m_rrequest = 1'b0;
      m_wrequest = 1'b0;
   endtask

   task automatic wait_resp();
      for (int i = 0; i < 60; i++) begin
         if (m_rresponse | m_wresponse) return;
         @(negedge clock);
      end
      chk("resp_timeout", 32'(1), 32'(0));
   endtask

   task automatic transact(input logic write, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic stall);
      issue(write, addr, data, strb, stall);
      wait_resp();
      @(negedge clock);
   endtask

   task automatic wait_long_delay();
      stall_enable = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (ref_lfsr[2:0] >= 3'd2) return;
         @(negedge clock);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_m_rdata"}, m_rdata, 32'h0);
      chk({tag, "_s_address"}, s_address, 32'h0);
      chk({tag, "_s_wdata"}, s_wdata, 32'h0);
      chk({tag, "_ctrl"}, 32'({s_wstrobe, s_rrequest, s_wrequest, m_rresponse, m_wresponse,
                               protocol_error}), 32'h0);
      chk({tag, "_stall_cnt"}, stall_cycles_count, 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int s0, r0;
      logic [31:0] wd;
      logic [3:0]  ws;

      mem[32'h100]      = 32'h1234_5678;
      exp_mem[32'h100]  = 32'h1234_5678;
      mem[32'h1000]     = 32'h1122_3344;
      exp_mem[32'h1000] = 32'h1122_3344;

      repeat (3) @(negedge clock);
      check_outputs_zero("reset");
      chk("reset_lfsr", 32'(dut.u_lfsr.value), 32'h0000_ACE1);
      reset = 1'b0;
      @(negedge clock);

      // Unstalled read of preloaded word.
      transact(1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
      chk("nostall_cnt", stall_cycles_count, 32'h0);

      // Partial-strobe write, bus fields checked during the ISSUE cycle.
      s0 = n_sreq;
      r0 = n_mresp;
      issue(1'b1, 32'h1000, 32'hDEAD_BEEF, 4'b0011, 1'b0);
      chk("strb_s_wrequest", 32'({s_wrequest, s_rrequest}), 32'h2);
      chk("strb_s_address", s_address, 32'h1000);
      chk("strb_s_wdata", s_wdata, 32'hDEAD_BEEF);
      chk("strb_s_wstrobe", 32'(s_wstrobe), 32'h3);
      wait_resp();
      @(negedge clock);
      chk("strb_sreq_pulses", n_sreq - s0, 1);
      chk("strb_mresp_pulses", n_mresp - r0, 1);
      transact(1'b0, 32'h1000, 32'h0, 4'h0, 1'b1);

      // Back-to-back stalled writes; stall_enable toggles mid-transaction.
      for (int i = 0; i < 100; i++) begin
         wd = $urandom;
         ws = (i % 5 == 0) ? 4'($urandom_range(1, 15)) : 4'hF;
         issue(1'b1, 32'h2000 + 32'(4 * (i % 40)), wd, ws, 1'b1);
         stall_enable = 1'($urandom_range(0, 1));
         wait_resp();
         @(negedge clock);
      end
      chk("writes_stall_cnt", stall_cycles_count, exp_stall);
      chk("writes_no_error", 32'(protocol_error), 32'h0);
      for (int k = 0; k < 8; k++) transact(1'b0, 32'h2000 + 32'(4 * k), 32'h0, 4'h0, 1'b1);
      chk("readback_stall_cnt", stall_cycles_count, exp_stall);

      // Second request while the first is still in DELAY.
      wait_long_delay();
      s0 = n_sreq;
      r0 = n_mresp;
      issue(1'b0, 32'h100, 32'h0, 4'h0, 1'b1);
      m_address  = 32'h2000;
      m_rrequest = 1'b1;
      @(negedge clock);
      m_rrequest = 1'b0;
      wait_resp();
      repeat (6) @(negedge clock);
      chk("busy_req_error", 32'(protocol_error), 32'h1);
      chk("busy_sreq_pulses", n_sreq - s0, 1);
      chk("busy_mresp_pulses", n_mresp - r0, 1);
      chk("busy_stall_cnt", stall_cycles_count, exp_stall);

      // Reset while waiting for the subordinate response.
      r0 = n_mresp;
      issue(1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      sb_q.delete();
      exp_stall = 0;
      @(negedge clock);
      check_outputs_zero("midrst");
      chk("midrst_lfsr", 32'(dut.u_lfsr.value), 32'h0000_ACE1);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_outputs_zero("postrst");
      repeat (5) @(negedge clock);
      chk("postrst_no_resp", n_mresp - r0, 0);
      transact(1'b0, 32'h1000, 32'h0, 4'h0, 1'b1);
      chk("postrst_no_error", 32'(protocol_error), 32'h0);

      // Stray subordinate response while idle.
      inj_wresp = 1'b1;
      @(negedge clock);
      inj_wresp = 1'b0;
      @(negedge clock);
      chk("idle_resp_error", 32'(protocol_error), 32'h1);

      // Saturation of the stall counter.
      force dut.stall_cycles_count = 32'hFFFF_FFFE;
      @(negedge clock);
      release dut.stall_cycles_count;
      @(negedge clock);
      chk("sat_preload", stall_cycles_count, 32'hFFFF_FFFE);
      wait_long_delay();
      transact(1'b0, 32'h100, 32'h0, 4'h0, 1'b1);
      chk("sat_stall_cnt", stall_cycles_count, 32'hFFFF_FFFF);
      chk("sat_queue_empty", 32'(sb_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rvx_bus_stall_injector.md
Name: rvx_bus_stall_injector

Overview:
- Sits on the RVX data or instruction bus between a manager (rvx_core dbus/ibus) and a subordinate (rvx_tightly_coupled_memory port).
- Registers each request, holds it for a pseudo-random number of wait cycles, forwards it, and returns the subordinate's response to the manager one cycle later.
- Its job is to stress core stall/handshake logic in simulation and FPGA bring-up in a synthesizable, reproducible way.

Parameters:
- MAX_WAIT_CYCLES, 7, upper bound of injected delay. Must be 2^W-1 with 1<=W<=8; W = clog2(MAX_WAIT_CYCLES+1).
- LFSR_SEED, 16'hACE1, LFSR reset value. A value of 0 is replaced by 16'h0001.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- stall_enable  in  1  1: random delay; 0: delay forced to 0
- m_address  in  32  manager address
- m_wdata  in  32  manager write data
- m_wstrobe  in  4  manager byte strobes
- m_rrequest  in  1  manager read request, one-cycle pulse
- m_wrequest  in  1  manager write request, one-cycle pulse
- m_rdata  out  32  read data to manager
- m_rresponse  out  1  read response to manager, one-cycle pulse
- m_wresponse  out  1  write response to manager, one-cycle pulse
- s_address  out  32  subordinate address
- s_wdata  out  32  subordinate write data
- s_wstrobe  out  4  subordinate strobes
- s_rrequest  out  1  subordinate read request
- s_wrequest  out  1  subordinate write request
- s_rdata  in  32  subordinate read data
- s_rresponse  in  1  subordinate read response
- s_wresponse  in  1  subordinate write response
- protocol_error  out  1  sticky error flag
- stall_cycles_count  out  32  total injected wait cycles, saturating

Behaviour:
Reset:
- All outputs are 0, state = IDLE, lfsr = LFSR_SEED.
- Reset mid-transaction discards the pending transaction; no response is ever issued for it.

LFSR:
- 16-bit Galois, mask 16'hB400, shifts right every cycle outside reset.
- Sampled delay d = lfsr[W-1:0] when stall_enable=1, else d = 0.

State machine (all outputs registered):
- IDLE: on m_rrequest|m_wrequest, latch address/wdata/wstrobe/kind and load the delay counter with d. Go to DELAY if d>0, else ISSUE.
- DELAY: decrement the counter each cycle and increment stall_cycles_count (saturate at 32'hFFFFFFFF). Go to ISSUE when the counter reaches 1.
- ISSUE: drive s_address/s_wdata/s_wstrobe from latches, pulse s_rrequest or s_wrequest for exactly one cycle, go to WAIT_RESP. s_address/s_wdata/s_wstrobe hold latched values until the transaction returns to IDLE.
- WAIT_RESP: on the s_*response matching the latched kind, capture s_rdata on reads and go to RESPOND. A response of the wrong kind sets protocol_error and is otherwise ignored.
- RESPOND: pulse m_rresponse or m_wresponse for one cycle with m_rdata valid (m_rdata holds until the next read capture), go to IDLE.

Latency:
- Request at cycle t → s_*request at t+1+d → manager response one cycle after the subordinate response.
- With a one-cycle TCM, the manager response arrives at t+3+d.

Boundary conditions:
- m_rrequest and m_wrequest high together: write wins, protocol_error set.
- Any m_*request while not IDLE: the request is dropped and protocol_error is set. The in-flight transaction is unaffected.
- s_*response while IDLE/DELAY/ISSUE: protocol_error set, response ignored.
- A request accepted in the same cycle RESPOND returns to IDLE is not possible. The request must arrive in IDLE; an earlier one counts as a not-IDLE request above.
- protocol_error clears only on reset.
- stall_enable is sampled only in IDLE at acceptance. Toggling it mid-transaction does not change the current delay.

Decomposition:
- Shared package rvx_bus_pkg holds:
  - state enum (IDLE, DELAY, ISSUE, WAIT_RESP, RESPOND)
  - LFSR mask constant 16'hB400
  - default seed
- One natural sub-module: rvx_lfsr16, with ports clock, reset, seed, value. It is reusable by other stress blocks.

Test Plan:
- stall_enable=0, TCM subordinate, read 0x00000100 holding 32'h12345678 at t=0 → s_rrequest at t=1, m_rresponse at t=3, m_rdata=32'h12345678, stall_cycles_count=0.
- stall_enable=1, LFSR_SEED default, 100 back-to-back writes → each m_wresponse latency = 3+d, where d matches the reference LFSR model. stall_cycles_count equals the sum of all d; memory contents correct.
- Write 32'hDEADBEEF with wstrobe=4'b0011 to 0x00001000 → s_wstrobe=4'b0011 and s_wdata exact; single s_wrequest pulse; single m_wresponse.
- Second m_rrequest issued during DELAY → protocol_error=1; the first transaction still completes with one m_rresponse; no second s_rrequest.
- Assert reset during WAIT_RESP, then release → all outputs 0 for the next cycle, no m_rresponse, lfsr=16'hACE1. The next read completes normally.
- Force stall_cycles_count to 32'hFFFFFFFE via a long run with MAX_WAIT_CYCLES=255, or by hierarchical force → it saturates at 32'hFFFFFFFF with no wrap.
